// File: rtl/grey_pkg.sv
// Shared Grey decade code constants and successor function.
// Used by the grey_10 counter and grey_bcd_decode.
package grey_pkg;

  typedef enum logic [4:0] {
    GC_ZERO  = 5'b10001,
    GC_ONE   = 5'b00001,
    GC_TWO   = 5'b00011,
    GC_THREE = 5'b00010,
    GC_FOUR  = 5'b00110,
    GC_FIVE  = 5'b00100,
    GC_SIX   = 5'b01100,
    GC_SEVEN = 5'b01000,
    GC_EIGHT = 5'b11000,
    GC_NINE  = 5'b10000
  } grey_code_e;

  localparam logic [3:0] DIGIT_MAX = 4'd9;

  function automatic logic [4:0] grey_succ(
    input logic [4:0] code
  );
    unique case (code)
      GC_ZERO:  grey_succ = GC_ONE;
      GC_ONE:   grey_succ = GC_TWO;
      GC_TWO:   grey_succ = GC_THREE;
      GC_THREE: grey_succ = GC_FOUR;
      GC_FOUR:  grey_succ = GC_FIVE;
      GC_FIVE:  grey_succ = GC_SIX;
      GC_SIX:   grey_succ = GC_SEVEN;
      GC_SEVEN: grey_succ = GC_EIGHT;
      GC_EIGHT: grey_succ = GC_NINE;
      default:  grey_succ = GC_ZERO;
    endcase
  endfunction

endpackage

// File: rtl/grey_code_lut.sv
// Combinational Grey decade code to BCD lookup.
// Flags the 22 unused codes as illegal.
module grey_code_lut
  import grey_pkg::*;
(
  input  logic [4:0] i_code,
  output logic [3:0] o_bcd,
  output logic       o_legal
);

  always_comb begin
    o_bcd   = 4'd0;
    o_legal = 1'b1;
    unique case (i_code)
      GC_ZERO:  o_bcd = 4'd0;
      GC_ONE:   o_bcd = 4'd1;
      GC_TWO:   o_bcd = 4'd2;
      GC_THREE: o_bcd = 4'd3;
      GC_FOUR:  o_bcd = 4'd4;
      GC_FIVE:  o_bcd = 4'd5;
      GC_SIX:   o_bcd = 4'd6;
      GC_SEVEN: o_bcd = 4'd7;
      GC_EIGHT: o_bcd = 4'd8;
      GC_NINE:  o_bcd = 4'd9;
      default:  o_legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/grey_bcd_decode.sv
// Two-stage Grey decade decoder with tens counter,
// roll-over detection and sticky code/sequence error flags.
module grey_bcd_decode
  import grey_pkg::*;
#(
  parameter bit pWRAP = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [4:0] i_cnt,
  input  logic       i_clk_div,
  input  logic       i_err_clr,
  output logic [3:0] o_bcd_ones,
  output logic [3:0] o_bcd_tens,
  output logic       o_valid,
  output logic       o_carry,
  output logic       o_ovf,
  output logic       o_err_code,
  output logic       o_err_seq
);

  logic [4:0] s1_cnt;
  logic       s1_div;
  logic       s1_vld;
  logic [4:0] prev_cnt;
  logic       prev_ok;
  logic       prev_div;
  logic [3:0] lut_bcd;
  logic       lut_legal;
  logic       fall;
  logic       roll;
  logic       bad_code;
  logic       bad_seq;
  logic [3:0] tens_nxt;
  logic       ovf_nxt;

  grey_code_lut u_lut (
    .i_code  (s1_cnt),
    .o_bcd   (lut_bcd),
    .o_legal (lut_legal)
  );

  always_comb begin
    fall     = s1_vld & prev_div & ~s1_div;
    roll     = fall & lut_legal & (lut_bcd == 4'd0);
    bad_code = s1_vld & ~lut_legal;
    bad_seq  = (fall & ~roll)
             | (s1_vld & lut_legal & prev_ok
                & (s1_cnt != grey_succ(prev_cnt)));
    tens_nxt = o_bcd_tens;
    ovf_nxt  = 1'b0;
    if (roll) begin
      if (o_bcd_tens != DIGIT_MAX) begin
        tens_nxt = o_bcd_tens + 4'd1;
      end else if (pWRAP) begin
        tens_nxt = 4'd0;
        ovf_nxt  = 1'b1;
      end
    end
  end

  // s1_vld keeps the empty post-reset stage from reading as a bad code
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_cnt <= 5'd0;
      s1_div <= 1'b0;
      s1_vld <= 1'b0;
    end else begin
      s1_cnt <= i_cnt;
      s1_div <= i_clk_div;
      s1_vld <= 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      prev_cnt <= 5'd0;
      prev_ok  <= 1'b0;
      prev_div <= 1'b0;
    end else if (s1_vld) begin
      prev_ok  <= lut_legal;
      prev_div <= s1_div;
      if (lut_legal) prev_cnt <= s1_cnt;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_bcd_ones <= 4'd0;
      o_bcd_tens <= 4'd0;
      o_valid    <= 1'b0;
      o_carry    <= 1'b0;
      o_ovf      <= 1'b0;
      o_err_code <= 1'b0;
      o_err_seq  <= 1'b0;
    end else begin
      o_valid    <= s1_vld & lut_legal;
      o_carry    <= roll;
      o_ovf      <= ovf_nxt;
      o_bcd_tens <= tens_nxt;
      o_err_code <= (o_err_code & ~i_err_clr) | bad_code;
      o_err_seq  <= (o_err_seq & ~i_err_clr) | bad_seq;
      if (s1_vld & lut_legal) o_bcd_ones <= lut_bcd;
    end
  end

endmodule

// File: tb/tb_grey_bcd_decode.sv
// Bench for grey_bcd_decode: both wrap modes side by side
// against an integer-digit reference model.
module tb_grey_bcd_decode;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] cnt = 5'd0;
  logic       div = 1'b0;
  logic       clr = 1'b0;

  logic [3:0] ones0, tens0, ones1, tens1;
  logic valid0, carry0, ovf0, ecode0, eseq0;
  logic valid1, carry1, ovf1, ecode1, eseq1;

  always #5 clk = ~clk;

  grey_bcd_decode #(.pWRAP(1'b0)) dut0 (
    .i_clk(clk), .i_rst(rst), .i_cnt(cnt),
    .i_clk_div(div), .i_err_clr(clr),
    .o_bcd_ones(ones0), .o_bcd_tens(tens0),
    .o_valid(valid0), .o_carry(carry0), .o_ovf(ovf0),
    .o_err_code(ecode0), .o_err_seq(eseq0)
  );

  grey_bcd_decode #(.pWRAP(1'b1)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_cnt(cnt),
    .i_clk_div(div), .i_err_clr(clr),
    .o_bcd_ones(ones1), .o_bcd_tens(tens1),
    .o_valid(valid1), .o_carry(carry1), .o_ovf(ovf1),
    .o_err_code(ecode1), .o_err_seq(eseq1)
  );

  logic [4:0] codes [10] = '{
    5'b10001, 5'b00001, 5'b00011, 5'b00010, 5'b00110,
    5'b00100, 5'b01100, 5'b01000, 5'b11000, 5'b10000
  };

  int n_chk = 0;
  int n_fail = 0;
  int g = 0;
  int n_carry, n_ovf0, n_ovf1, tens_keep;

  // reference model state (digits as integers)
  logic [4:0] m_s1c;
  bit m_s1d, m_s1v, m_pok, m_pdiv;
  int m_pdig, m_ones, m_tens [2];
  bit m_valid, m_carry, m_ovf [2], m_ecode, m_eseq;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, obs, exp);
    end
  endtask

  task automatic model(input bit r, input logic [4:0] c,
                       input bit d, input bit cl);
    int dig;
    bit fall, nc, ns;
    if (r) begin
      m_s1c = 0; m_s1d = 0; m_s1v = 0;
      m_pok = 0; m_pdiv = 0; m_pdig = 0;
      m_ones = 0; m_tens = '{0, 0};
      m_valid = 0; m_carry = 0; m_ovf = '{0, 0};
      m_ecode = 0; m_eseq = 0;
    end else begin
      dig = -1;
      for (int i = 0; i < 10; i++)
        if (codes[i] == m_s1c) dig = i;
      nc = 0; ns = 0;
      m_carry = 0; m_ovf = '{0, 0};
      m_valid = 0;
      if (m_s1v) begin
        fall = m_pdiv && !m_s1d;
        m_valid = (dig >= 0);
        if (dig < 0) nc = 1;
        else begin
          m_ones = dig;
          if (m_pok && dig != (m_pdig + 1) % 10) ns = 1;
        end
        if (fall && dig == 0) begin
          m_carry = 1;
          for (int w = 0; w < 2; w++) begin
            if (m_tens[w] < 9) m_tens[w]++;
            else if (w == 1) begin
              m_tens[w] = 0;
              m_ovf[w] = 1;
            end
          end
        end else if (fall) ns = 1;
        m_pok = (dig >= 0);
        if (dig >= 0) m_pdig = dig;
        m_pdiv = m_s1d;
      end
      m_ecode = (m_ecode && !cl) || nc;
      m_eseq = (m_eseq && !cl) || ns;
      m_s1c = c; m_s1d = d; m_s1v = 1;
    end
  endtask

  task automatic step(input bit r, input logic [4:0] c,
                      input bit d, input bit cl);
    rst = r; cnt = c; div = d; clr = cl;
    @(posedge clk);
    model(r, c, d, cl);
    #1;
    chk("ones1", ones1, m_ones);
    chk("tens1", tens1, m_tens[1]);
    chk("valid1", valid1, m_valid);
    chk("carry1", carry1, m_carry);
    chk("ovf1", ovf1, m_ovf[1]);
    chk("ecode1", ecode1, m_ecode);
    chk("eseq1", eseq1, m_eseq);
    chk("ones0", ones0, m_ones);
    chk("tens0", tens0, m_tens[0]);
    chk("valid0", valid0, m_valid);
    chk("carry0", carry0, m_carry);
    chk("ovf0", ovf0, m_ovf[0]);
    chk("ecode0", ecode0, m_ecode);
    chk("eseq0", eseq0, m_eseq);
    if (carry1) n_carry++;
    if (ovf0) n_ovf0++;
    if (ovf1) n_ovf1++;
  endtask

  // one tick of an ideal grey_10 counter
  task automatic count(input bit cl);
    step(0, codes[g], g >= 5, cl);
    g = (g + 1) % 10;
  endtask

  task automatic do_reset();
    step(1, 5'd0, 1'b0, 1'b0);
    step(1, 5'd0, 1'b0, 1'b0);
    g = 0;
    n_carry = 0; n_ovf0 = 0; n_ovf1 = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    model(1, 5'd0, 0, 0);
    do_reset();
    chk("rst_valid", valid1, 0);
    chk("rst_tens", tens1, 0);

    // 25 decade codes from ZERO
    repeat (25) count(0);
    chk("basic_carries", n_carry, 2);
    chk("basic_tens", tens1, 2);
    chk("basic_err", {ecode1, eseq1}, 0);

    // 100 decades: first wrap, then the rest
    do_reset();
    repeat (102) count(0);
    chk("wrap_ovf_once", n_ovf1, 1);
    chk("wrap_tens1", tens1, 0);
    chk("sat_tens0", tens0, 9);
    repeat (900) count(0);
    chk("wrap_ovf_100", n_ovf1, 10);
    chk("sat_ovf_none", n_ovf0, 0);
    chk("sat_tens0_end", tens0, 9);

    // illegal code mid-count
    while (g != 2) count(0);
    count(0);
    step(0, 5'b11111, 1'b0, 1'b0);
    count(0);
    chk("ill_valid", valid1, 0);
    chk("ill_ones_held", ones1, 2);
    chk("ill_ecode", ecode1, 1);
    count(0);
    chk("ill_resume_valid", valid1, 1);
    chk("ill_resume_seq", eseq1, 0);

    // THREE then FIVE, then clear, then clear with skip
    while (g != 3) count(0);
    count(0);
    g = 5;
    count(0);
    count(0);
    count(0);
    chk("skip_seq", eseq1, 1);
    count(1);
    chk("clr_seq", eseq1, 0);
    chk("clr_code", ecode1, 0);
    while (g != 1) count(0);
    count(0);
    g = 3;
    count(0);
    count(1);
    chk("clr_vs_new", eseq1, 1);

    // falling clk_div on SEVEN
    while (g != 5) count(0);
    count(1);
    count(0);
    tens_keep = m_tens[1];
    step(0, codes[7], 1'b0, 1'b0);
    g = 8;
    count(0);
    chk("fall7_seq", eseq1, 1);
    chk("fall7_carry", carry1, 0);
    chk("fall7_tens", tens1, tens_keep);

    // reset at tens=5 with clk_div high
    do_reset();
    repeat (55) count(0);
    chk("pre_rst_tens", tens1, 5);
    step(1, codes[5], 1'b1, 1'b0);
    step(1, codes[6], 1'b1, 1'b0);
    chk("rst_all", {ones1, tens1, valid1, carry1,
                    ovf1, ecode1, eseq1}, 0);
    step(0, codes[0], 1'b0, 1'b0);
    chk("rel_valid0", valid1, 0);
    step(0, codes[1], 1'b0, 1'b0);
    chk("rel_valid1", valid1, 1);
    chk("rel_carry", carry1, 0);
    chk("rel_tens", tens1, 0);

    // randomized traffic with injected faults
    do_reset();
    repeat (400) begin
      r = $urandom_range(0, 19);
      if (r == 0)
        step(0, 5'($urandom), 1'($urandom), 1'b0);
      else if (r == 1)
        count(1);
      else if (r == 2) begin
        g = $urandom_range(0, 9);
        count(0);
      end else if (r == 3)
        step(0, codes[g], 1'($urandom), 1'($urandom));
      else
        count(0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
